// File: rtl/inst_loader.sv
// Instruction RAM loader: streams program words into the instruction RAM, then releases the CPU.
// Optional checksum verification of the loaded image is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter logic [31:0] PC_INITIAL    = 32'hbfc00000,
  parameter int unsigned MAX_WORDS     = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
`ifdef INST_LOADER_CHECKSUM_EN
  input  logic [31:0] expected_sum,
  output logic [31:0] checksum,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        cpu_reset,
  output logic        debug,
  output logic [15:0] word_count,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        load_ready_q, load_ready_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] waddr_q, waddr_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        debug_q, debug_d;
  logic [15:0] word_count_q, word_count_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        accept_s;
  logic        sum_bad_s;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] sum_next_s;
  assign sum_next_s = sum_q + load_data;
  assign sum_bad_s  = (sum_next_s != expected_sum);
  assign checksum   = sum_q;
`else
  assign sum_bad_s  = 1'b0;
`endif

  assign accept_s = (state_q == ST_LOAD) && load_valid && load_ready_q;

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d      = state_q;
    load_ready_d = load_ready_q;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    cpu_reset_d  = cpu_reset_q;
    debug_d      = debug_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    error_d      = error_q;
    settle_cnt_d = settle_cnt_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          state_d      = ST_LOAD;
          load_ready_d = 1'b1;
          word_count_d = 16'd0;
          error_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d        = 32'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          we_d         = 1'b1;
          wdata_d      = load_data;
          waddr_d      = PC_INITIAL + {14'd0, word_count_q, 2'b00};
          word_count_d = word_count_q + 16'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d        = sum_next_s;
`endif
          // The last word wins over the length limit; a bad checksum on it still faults.
          if (load_last && !sum_bad_s) begin
            state_d      = ST_SETTLE;
            load_ready_d = 1'b0;
            settle_cnt_d = 8'd0;
          end else if (load_last || (word_count_q == 16'(MAX_WORDS - 1))) begin
            state_d      = ST_FAULT;
            load_ready_d = 1'b0;
            error_d      = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'(SETTLE_CYCLES)) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
          debug_d     = 1'b0;
          done_d      = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      load_ready_q <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      waddr_q      <= PC_INITIAL;
      cpu_reset_q  <= 1'b1;
      debug_q      <= 1'b1;
      word_count_q <= 16'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      settle_cnt_q <= 8'd0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      cpu_reset_q  <= cpu_reset_d;
      debug_q      <= debug_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign load_ready             = load_ready_q;
  assign inst_ram_write_enable  = we_q;
  assign inst_ram_write_data    = wdata_q;
  assign inst_ram_write_address = waddr_q;
  assign cpu_reset              = cpu_reset_q;
  assign debug                  = debug_q;
  assign word_count             = word_count_q;
  assign done                   = done_q;
  assign error                  = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (MAX_WORDS=4, SETTLE_CYCLES=4).
module tb_inst_loader;
  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset, start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, we, cpu_reset, debug, done, error;
  logic [31:0] wdata, waddr;
  logic [15:0] word_count;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] expected_sum, checksum;
`endif

  int checks = 0;
  int errors = 0;

  inst_loader #(
    .PC_INITIAL(32'hbfc00000), .MAX_WORDS(4), .SETTLE_CYCLES(SETTLE)
  ) dut (
`ifdef INST_LOADER_CHECKSUM_EN
    .expected_sum(expected_sum), .checksum(checksum),
`endif
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .inst_ram_write_enable(we), .inst_ram_write_data(wdata),
    .inst_ram_write_address(waddr), .cpu_reset(cpu_reset), .debug(debug),
    .word_count(word_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_waddr"}, waddr, 32'hbfc00000);
    check({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_debug"}, {31'd0, debug}, 32'd1);
    check({tag, "_wc"}, {16'd0, word_count}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
`ifdef INST_LOADER_CHECKSUM_EN
    expected_sum = 32'h421F831C;
`endif
    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Basic three-word load
    do_start();
    check("t1_ready", {31'd0, load_ready}, 32'd1);
    send(32'h200F0AF4, 1'b0);
    check("t1_we0", {31'd0, we}, 32'd1);
    check("t1_data0", wdata, 32'h200F0AF4);
    check("t1_addr0", waddr, 32'hbfc00000);
    check("t1_wc1", {16'd0, word_count}, 32'd1);
    send(32'h20180008, 1'b0);
    check("t1_data1", wdata, 32'h20180008);
    check("t1_addr1", waddr, 32'hbfc00004);
    send(32'h01F87820, 1'b1);
    check("t1_we2", {31'd0, we}, 32'd1);
    check("t1_data2", wdata, 32'h01F87820);
    check("t1_addr2", waddr, 32'hbfc00008);
    check("t1_wc3", {16'd0, word_count}, 32'd3);
    check("t1_ready_off", {31'd0, load_ready}, 32'd0);
    for (int i = 0; i < SETTLE; i++) begin
      tick();
      check("t1_settle_cpurst", {31'd0, cpu_reset}, 32'd1);
      check("t1_settle_we", {31'd0, we}, 32'd0);
    end
    tick();
    check("t1_run_cpurst", {31'd0, cpu_reset}, 32'd0);
    check("t1_run_debug", {31'd0, debug}, 32'd0);
    check("t1_run_done", {31'd0, done}, 32'd1);
    check("t1_run_wc", {16'd0, word_count}, 32'd3);
    do_start();
    check("t1_run_ign_done", {31'd0, done}, 32'd1);
    check("t1_run_ign_ready", {31'd0, load_ready}, 32'd0);

    // Bubbles: valid 1,0,0,1(last), with a start attempted mid-load
    do_reset();
`ifdef INST_LOADER_CHECKSUM_EN
    expected_sum = 32'h33333333;
`endif
    do_start();
    send(32'h11111111, 1'b0);
    check("t2_we0", {31'd0, we}, 32'd1);
    check("t2_addr0", waddr, 32'hbfc00000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_bubble1_we", {31'd0, we}, 32'd0);
    tick();
    check("t2_bubble2_we", {31'd0, we}, 32'd0);
    check("t2_bubble_wc", {16'd0, word_count}, 32'd1);
    send(32'h22222222, 1'b1);
    check("t2_we1", {31'd0, we}, 32'd1);
    check("t2_addr1", waddr, 32'hbfc00004);
    check("t2_data1", wdata, 32'h22222222);
    check("t2_wc", {16'd0, word_count}, 32'd2);
    tick();
    check("t2_after_we", {31'd0, we}, 32'd0);

    // Overflow at MAX_WORDS=4 and restart from FAULT
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(32'hA000_0000 + i, 1'b0);
      check("t3_we", {31'd0, we}, 32'd1);
      check("t3_addr", waddr, 32'hbfc00000 + 32'(4 * i));
    end
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_cpurst", {31'd0, cpu_reset}, 32'd1);
    check("t3_ready", {31'd0, load_ready}, 32'd0);
    check("t3_wc", {16'd0, word_count}, 32'd4);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("t3_fault_we", {31'd0, we}, 32'd0);
    check("t3_fault_error", {31'd0, error}, 32'd1);
`ifdef INST_LOADER_CHECKSUM_EN
    expected_sum = 32'h000000A5;
`endif
    do_start();
    check("t3_restart_error", {31'd0, error}, 32'd0);
    check("t3_restart_wc", {16'd0, word_count}, 32'd0);
    check("t3_restart_ready", {31'd0, load_ready}, 32'd1);
    send(32'h000000A5, 1'b1);
    check("t3_restart_addr", waddr, 32'hbfc00000);
    check("t3_restart_we", {31'd0, we}, 32'd1);

    // Reset after the 2nd accepted word
    do_reset();
    do_start();
    send(32'h00000001, 1'b0);
    send(32'h00000002, 1'b0);
    check("t4_we1", {31'd0, we}, 32'd1);
    check("t4_addr1", waddr, 32'hbfc00004);
    reset = 1'b1; start = 1'b1; load_valid = 1'b1; load_data = 32'h00000003;
    tick();
    check_reset_vals("t4_rst1");
    tick();
    check_reset_vals("t4_rst2");
    reset = 1'b0; start = 1'b0; load_valid = 1'b0;
    tick();
    check("t4_idle_ready", {31'd0, load_ready}, 32'd0);
    check("t4_idle_we", {31'd0, we}, 32'd0);

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum pass and fail
    do_reset();
    expected_sum = 32'd6;
    do_start();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    check("t5_sum", checksum, 32'd6);
    for (int i = 0; i <= SETTLE; i++) tick();
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_error", {31'd0, error}, 32'd0);
    do_reset();
    expected_sum = 32'd7;
    do_start();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    check("t5b_error", {31'd0, error}, 32'd1);
    check("t5b_cpurst", {31'd0, cpu_reset}, 32'd1);
    check("t5b_sum", checksum, 32'd6);
    for (int i = 0; i <= SETTLE; i++) tick();
    check("t5b_done", {31'd0, done}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
